serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/full_subtractor_bit.sv | 13 +
 rtl/serial_subtractor.sv | 118 +++++++++++
 tb/tb_serial_subtractor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encoding
// and the default operand width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bIn, with borrow-out.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bIn,
    output logic d,
    output logic bOut
);

    assign d    = a ^ b ^ bIn;
    assign bOut = (~a & b) | (~a & bIn) | (b & bIn);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bIn,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] diff,
    output logic             bOut,
    output logic             valid
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             br;
    logic             d_bit;
    logic             br_next;
    logic             last_step;
    logic             accept;

    // The single cell always works on the LSBs of the right-shifting operands.
    full_subtractor_bit u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bIn  (br),
        .d    (d_bit),
        .bOut (br_next)
    );

    assign last_step = (state == SHIFT) && (bit_cnt == LAST_BIT);
    assign accept    = start && ready;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? SHIFT : IDLE;
            SHIFT:   next_state = (bit_cnt == LAST_BIT) ? DONE : SHIFT;
            DONE:    next_state = start ? SHIFT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            SHIFT:   busy  = 1'b1;
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // diff fills from the MSB side, so after WIDTH steps bit 0 sits at diff[0].
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bit_cnt <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            br      <= 1'b0;
            diff    <= '0;
            bOut    <= 1'b0;
            valid   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            if (accept) begin
                a_sh    <= a;
                b_sh    <= b;
                br      <= bIn;
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                diff <= {d_bit, diff[WIDTH-1:1]};
                a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                br   <= br_next;
                if (last_step) begin
                    bOut  <= br_next;
                    valid <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    ovf   <= (a_sh[0] != b_sh[0]) && (d_bit != a_sh[0]);
`endif
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model checked
// every cycle, plus directed operations with hand-computed results.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         Clk;
    logic         Rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bIn;
    logic         ready;
    logic         busy;
    logic [W-1:0] diff;
    logic         bOut;
    logic         valid;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int nPass  = 0;
    int nTotal = 0;
    bit checkEn = 0;

    // Reference model state: cycles left before the result appears
    int           busyLeft  = 0;
    logic [W-1:0] pendDiff  = '0;
    logic         pendBout  = 1'b0;
    logic         pendOvf   = 1'b0;
    logic [W-1:0] expDiff   = '0;
    logic         expBout   = 1'b0;
    logic         expOvf    = 1'b0;
    logic         expValid  = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bIn   (bIn),
        .ready (ready),
        .busy  (busy),
        .diff  (diff),
        .bOut  (bOut),
        .valid (valid)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        nTotal++;
        if (act == exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model works from plain integer arithmetic on the accepted operands
    always @(posedge Clk) begin
        if (Rst) begin
            busyLeft = 0;
            expDiff  = '0;
            expBout  = 1'b0;
            expOvf   = 1'b0;
            expValid = 1'b0;
        end else begin
            expValid = 1'b0;
            if (busyLeft > 0) begin
                busyLeft--;
                if (busyLeft == 0) begin
                    expDiff  = pendDiff;
                    expBout  = pendBout;
                    expOvf   = pendOvf;
                    expValid = 1'b1;
                end
            end else if (start) begin
                int full;
                int sa;
                int sb;
                int sres;
                full     = int'(a) - int'(b) - int'(bIn);
                pendDiff = full[W-1:0];
                pendBout = (int'(a) < int'(b) + int'(bIn));
                sa       = a[W-1] ? int'(a) - (1 << W) : int'(a);
                sb       = b[W-1] ? int'(b) - (1 << W) : int'(b);
                sres     = sa - sb - int'(bIn);
                pendOvf  = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
                busyLeft = W;
            end
        end
    end

    always @(negedge Clk) begin
        if (checkEn) begin
            checkOutput("valid", int'(valid), int'(expValid));
            checkOutput("ready", int'(ready), int'(busyLeft == 0));
            checkOutput("busy", int'(busy), int'(busyLeft != 0));
            if (busyLeft == 0) begin
                checkOutput("diff", int'(diff), int'(expDiff));
                checkOutput("bOut", int'(bOut), int'(expBout));
`ifdef SERIAL_SUB_OVF_EN
                checkOutput("ovf", int'(ovf), int'(expOvf));
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting edge
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tbin);
        int guard = 0;
        while (!ready && guard < 50) begin
            @(negedge Clk);
            guard++;
        end
        if (!ready) checkOutput("ready_timeout", 0, 1);
        a     = ta;
        b     = tb_;
        bIn   = tbin;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        while (!valid && cycles < 20) begin
            @(negedge Clk);
            cycles++;
        end
        if (!valid) checkOutput("valid_timeout", 0, 1);
    endtask

    task automatic runOp(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tbin, input logic [W-1:0] eDiff, input logic eBout);
        int cyc;
        applyStimulus(ta, tb_, tbin);
        waitValid(cyc);
        checkOutput({name, "_latency"}, cyc, W);
        checkOutput({name, "_diff"}, int'(diff), int'(eDiff));
        checkOutput({name, "_bOut"}, int'(bOut), int'(eBout));
    endtask

    initial begin
        int cyc;
        logic [W-1:0] sum;
        Rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bIn   = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        checkEn = 1;
        checkOutput("rst_ready", int'(ready), 1);
        checkOutput("rst_diff", int'(diff), 0);
        checkOutput("rst_valid", int'(valid), 0);
        Rst = 1'b0;
        @(negedge Clk);

        runOp("basic", 4'b1011, 4'b0011, 1'b0, 4'b1000, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("basic_ovf", int'(ovf), 0);
`endif
        @(negedge Clk);
        checkOutput("valid_one_cycle", int'(valid), 0);
        checkOutput("held_diff", int'(diff), 4'b1000);

        runOp("underflow", 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1);

        // Back-to-back: start stays high through SHIFT and is taken in DONE
        applyStimulus(4'b1010, 4'b1100, 1'b1);
        a     = 4'b1111;
        b     = 4'b1111;
        bIn   = 1'b0;
        start = 1'b1;
        waitValid(cyc);
        checkOutput("b2b_first_diff", int'(diff), 4'b1101);
        checkOutput("b2b_first_bOut", int'(bOut), 1);
        @(negedge Clk);
        start = 1'b0;
        waitValid(cyc);
        checkOutput("b2b_gap", cyc + 1, W + 1);
        checkOutput("b2b_second_diff", int'(diff), 4'b0000);
        checkOutput("b2b_second_bOut", int'(bOut), 0);

        // Start pulses mid-SHIFT must not disturb the operands in flight
        applyStimulus(4'b0110, 4'b0010, 1'b0);
        a     = 4'b1111;
        b     = 4'b0001;
        start = 1'b1;
        checkOutput("ign_busy", int'(busy), 1);
        checkOutput("ign_ready", int'(ready), 0);
        @(negedge Clk);
        a = 4'b0000;
        b = 4'b1111;
        @(negedge Clk);
        start = 1'b0;
        waitValid(cyc);
        checkOutput("ign_diff", int'(diff), 4'b0100);
        checkOutput("ign_bOut", int'(bOut), 0);
        @(negedge Clk);

        // Reset in the middle of a shift
        applyStimulus(4'b1100, 4'b0001, 1'b0);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        checkOutput("midrst_ready", int'(ready), 1);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_valid", int'(valid), 0);
        checkOutput("midrst_diff", int'(diff), 0);
        checkOutput("midrst_bOut", int'(bOut), 0);
        runOp("after_rst", 4'b1100, 4'b0001, 1'b0, 4'b1011, 1'b0);

        sum = 4'b0101 + 4'b0110;
        runOp("roundtrip", sum, 4'b0110, 1'b0, 4'b0101, 1'b0);
        runOp("equal_borrow", 4'b0011, 4'b0011, 1'b1, 4'b1111, 1'b1);

`ifdef SERIAL_SUB_OVF_EN
        runOp("ovf_pos", 4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1);
        checkOutput("ovf_pos_flag", int'(ovf), 1);
        runOp("ovf_none", 4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0);
        checkOutput("ovf_none_flag", int'(ovf), 0);
`endif

        repeat (3) @(negedge Clk);
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
